// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline-side signal bundle for the hazard/stall controller
interface hazard_stall_unit_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      IR_FD;
  logic [31:0]      IR_DX;
  logic [31:0]      ctrl_dx;
  logic             branch_taken;
  logic             multdiv_ready;
  logic             multdiv_exception;
  logic [31:0]      multdiv_result;

  logic             stall_pc;
  logic             stall_fd;
  logic             stall_dx;
  logic             flush_fd;
  logic             nop_dx;
  logic             nop_xm;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [31:0]      md_result;
  logic             md_valid;
  logic             md_exception;
  logic [CNT_W-1:0] stall_count;

  // Pipeline datapath side: supplies latch contents, consumes stall/flush controls
  modport master (
    output IR_FD, IR_DX, ctrl_dx, branch_taken,
           multdiv_ready, multdiv_exception, multdiv_result,
    input  stall_pc, stall_fd, stall_dx, flush_fd, nop_dx, nop_xm,
           ctrl_MULT, ctrl_DIV, md_result, md_valid, md_exception, stall_count
  );

  // Hazard controller side
  modport slave (
    input  IR_FD, IR_DX, ctrl_dx, branch_taken,
           multdiv_ready, multdiv_exception, multdiv_result,
    output stall_pc, stall_fd, stall_dx, flush_fd, nop_dx, nop_xm,
           ctrl_MULT, ctrl_DIV, md_result, md_valid, md_exception, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use stall, branch flush and multdiv sequencing for the F/D and D/X latches
module hazard_stall_unit #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  hazard_stall_unit_if.slave  hz
);
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam int         TW       = $clog2(MD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t        state, state_nxt;
  logic [TW-1:0]    md_cnt, md_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic [31:0]      md_result_q;
  logic             md_exception_q;
  logic             md_valid_q;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_alu, ld_dst;
  logic       dx_is_mul, dx_is_div;
  logic       fd_reads_dst, load_use, lu_stall;
  logic       md_stall, start_mult, start_div, md_timeout;
  logic       unused_bits;

  assign fd_op  = hz.IR_FD[31:27];
  assign fd_rd  = hz.IR_FD[26:22];
  assign fd_rs  = hz.IR_FD[21:17];
  assign fd_rt  = hz.IR_FD[16:12];
  assign dx_op  = hz.IR_DX[31:27];
  assign dx_alu = hz.IR_DX[6:2];
  assign ld_dst = hz.ctrl_dx[31:27];

  assign dx_is_mul  = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_is_div  = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);
  assign md_timeout = (md_cnt == TW'(MD_TIMEOUT - 1));

  // Which F/D source fields the load result would feed; sw data comes via the memory bypass
  always_comb begin
    fd_reads_dst = 1'b0;
    case (fd_op)
      OP_RTYPE:              fd_reads_dst = (fd_rs == ld_dst) || (fd_rt == ld_dst);
      OP_ADDI, OP_LW, OP_SW: fd_reads_dst = (fd_rs == ld_dst);
      OP_BNE, OP_BLT:        fd_reads_dst = (fd_rd == ld_dst) || (fd_rs == ld_dst);
      OP_JR:                 fd_reads_dst = (fd_rd == ld_dst);
      default:               fd_reads_dst = 1'b0;
    endcase
  end

  assign load_use = hz.ctrl_dx[13] && hz.ctrl_dx[15] && (ld_dst != 5'd0) && fd_reads_dst;

  // Multdiv sequencer: start pulse in IDLE, stall while BUSY, one release cycle in DONE
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    md_stall   = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    case (state)
      IDLE: begin
        if (dx_is_mul || dx_is_div) begin
          start_mult = dx_is_mul;
          start_div  = dx_is_div;
          md_stall   = 1'b1;
          md_cnt_nxt = '0;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        md_stall   = 1'b1;
        md_cnt_nxt = md_cnt + 1'b1;
        if (hz.multdiv_ready || md_timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, BUSY cycle counter and the completing result/exception
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      md_cnt         <= '0;
      md_result_q    <= '0;
      md_exception_q <= 1'b0;
      md_valid_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      md_cnt     <= md_cnt_nxt;
      md_valid_q <= (state == BUSY) && (hz.multdiv_ready || md_timeout);
      if (state == BUSY) begin
        if (hz.multdiv_ready) begin
          md_result_q    <= hz.multdiv_result;
          md_exception_q <= hz.multdiv_exception;
        end else if (md_timeout) begin
          md_result_q    <= '0;
          md_exception_q <= 1'b1;
        end
      end
    end
  end

  // Load-use only fires from IDLE; a redirect or a multdiv stall takes precedence
  assign lu_stall = reset_n && load_use && (state == IDLE) && !md_stall && !hz.branch_taken;

  assign hz.stall_pc     = (reset_n && md_stall) || lu_stall;
  assign hz.stall_fd     = (reset_n && md_stall) || lu_stall;
  assign hz.stall_dx     = reset_n && md_stall;
  assign hz.nop_xm       = reset_n && md_stall;
  assign hz.flush_fd     = reset_n && hz.branch_taken;
  assign hz.nop_dx       = (reset_n && hz.branch_taken) || lu_stall;
  assign hz.ctrl_MULT    = reset_n && start_mult;
  assign hz.ctrl_DIV     = reset_n && start_div;
  assign hz.md_result    = md_result_q;
  assign hz.md_valid     = md_valid_q;
  assign hz.md_exception = md_exception_q;
  assign hz.stall_count  = stall_cnt;

  // Saturating count of PC-hold cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (hz.stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign unused_bits = ^{hz.IR_FD[11:0], hz.IR_DX[26:7], hz.IR_DX[1:0],
                         hz.ctrl_dx[26:16], hz.ctrl_dx[14], hz.ctrl_dx[12:0]};
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  // control vector order: stall_pc stall_fd stall_dx flush_fd nop_dx nop_xm ctrl_MULT ctrl_DIV md_valid
  localparam logic [8:0] Q_NONE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] Q_LU    = 9'b1_1_0_0_1_0_0_0_0;
  localparam logic [8:0] Q_FLUSH = 9'b0_0_0_1_1_0_0_0_0;
  localparam logic [8:0] Q_BUSY  = 9'b1_1_1_0_0_1_0_0_0;
  localparam logic [8:0] Q_MULT  = 9'b1_1_1_0_0_1_1_0_0;
  localparam logic [8:0] Q_DIV   = 9'b1_1_1_0_0_1_0_1_0;
  localparam logic [8:0] Q_DONE  = 9'b0_0_0_0_0_0_0_0_1;

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] cnt;
    logic        chk_md;
    logic        mexc;
    logic [31:0] mres;
  } exp_t;

  typedef struct {
    logic [31:0] fd;
    logic [31:0] ctl;
    logic        hit;
  } lu_vec_t;

  logic clock = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  int unsigned exp_cnt = 0;
  exp_t sb[$];
  string nm[9] = '{"stall_pc", "stall_fd", "stall_dx", "flush_fd", "nop_dx",
                   "nop_xm", "ctrl_MULT", "ctrl_DIV", "md_valid"};

  hazard_stall_unit_if #(.CNT_W(32)) hz ();

  hazard_stall_unit #(.MD_TIMEOUT(40), .CNT_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .hz      (hz)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
    return {op, rd, rs, 17'd0};
  endfunction

  function automatic logic [31:0] ctrlw(input logic [4:0] dst, input logic rwe, input logic m2r);
    return {dst, 11'd0, rwe, 1'b0, m2r, 13'd0};
  endfunction

  function automatic logic [8:0] obs_ctl();
    return {hz.stall_pc, hz.stall_fd, hz.stall_dx, hz.flush_fd, hz.nop_dx,
            hz.nop_xm, hz.ctrl_MULT, hz.ctrl_DIV, hz.md_valid};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Queue this cycle's expectation, then advance to just after the next rising edge
  task automatic cyc(input logic [8:0] ctl, input logic chk_md, input logic mexc,
                     input logic [31:0] mres);
    exp_t e;
    e.ctl = ctl; e.cnt = 32'(exp_cnt); e.chk_md = chk_md; e.mexc = mexc; e.mres = mres;
    sb.push_back(e);
    if (ctl[8]) exp_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {23'd0, obs_ctl()}, 32'd0);
    check({tag, "_stall_count"}, hz.stall_count, 32'd0);
    check({tag, "_md_result"}, hz.md_result, 32'd0);
    check({tag, "_md_exception"}, {31'd0, hz.md_exception}, 32'd0);
  endtask

  task automatic set_in(input logic [31:0] fd, input logic [31:0] dx, input logic [31:0] cdx,
                        input logic br);
    hz.IR_FD = fd; hz.IR_DX = dx; hz.ctrl_dx = cdx; hz.branch_taken = br;
  endtask

  // Compare each queued expectation against the DUT mid-cycle
  always @(negedge clock) begin : monitor
    exp_t e;
    logic [8:0] o;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      o = obs_ctl();
      for (int i = 0; i < 9; i++) check(nm[i], 32'(o[8-i]), 32'(e.ctl[8-i]));
      check("stall_count", hz.stall_count, e.cnt);
      if (e.chk_md) begin
        check("md_result", hz.md_result, e.mres);
        check("md_exception", {31'd0, hz.md_exception}, {31'd0, e.mexc});
      end
    end
  end

  initial begin
    lu_vec_t lu[14];
    logic [31:0] lw3, mul_i, div_i;
    lw3   = itype(OP_LW, 5'd3, 5'd0);
    mul_i = rtype(5'd5, 5'd1, 5'd2, 5'b00110);
    div_i = rtype(5'd6, 5'd1, 5'd2, 5'b00111);
    lu[0]  = '{rtype(5'd4, 5'd3, 5'd5, 5'd0), ctrlw(5'd3, 1'b1, 1'b1), 1'b1};
    lu[1]  = '{rtype(5'd4, 5'd5, 5'd3, 5'd0), ctrlw(5'd3, 1'b1, 1'b1), 1'b1};
    lu[2]  = '{rtype(5'd4, 5'd0, 5'd5, 5'd0), ctrlw(5'd0, 1'b1, 1'b1), 1'b0};
    lu[3]  = '{itype(OP_SW, 5'd3, 5'd6),      ctrlw(5'd3, 1'b1, 1'b1), 1'b0};
    lu[4]  = '{itype(OP_SW, 5'd5, 5'd3),      ctrlw(5'd3, 1'b1, 1'b1), 1'b1};
    lu[5]  = '{itype(OP_ADDI, 5'd8, 5'd3),    ctrlw(5'd3, 1'b1, 1'b1), 1'b1};
    lu[6]  = '{itype(OP_ADDI, 5'd3, 5'd9),    ctrlw(5'd3, 1'b1, 1'b1), 1'b0};
    lu[7]  = '{itype(OP_LW, 5'd7, 5'd3),      ctrlw(5'd3, 1'b1, 1'b1), 1'b1};
    lu[8]  = '{itype(OP_BNE, 5'd3, 5'd7),     ctrlw(5'd3, 1'b1, 1'b1), 1'b1};
    lu[9]  = '{itype(OP_BLT, 5'd7, 5'd3),     ctrlw(5'd3, 1'b1, 1'b1), 1'b1};
    lu[10] = '{itype(OP_JR, 5'd3, 5'd0),      ctrlw(5'd3, 1'b1, 1'b1), 1'b1};
    lu[11] = '{rtype(5'd4, 5'd3, 5'd5, 5'd0), ctrlw(5'd3, 1'b0, 1'b1), 1'b0};
    lu[12] = '{rtype(5'd4, 5'd3, 5'd5, 5'd0), ctrlw(5'd3, 1'b1, 1'b0), 1'b0};
    lu[13] = '{rtype(5'd4, 5'd6, 5'd7, 5'd0), ctrlw(5'd3, 1'b1, 1'b1), 1'b0};

    // Reset with every hazard source active: all outputs must stay low
    reset_n = 1'b0;
    set_in(lu[0].fd, mul_i, lu[0].ctl, 1'b1);
    hz.multdiv_ready = 1'b1; hz.multdiv_exception = 1'b1; hz.multdiv_result = 32'hFFFF_FFFF;
    #7;
    check_all_zero("reset");
    hz.multdiv_ready = 1'b0; hz.multdiv_exception = 1'b0; hz.multdiv_result = 32'd0;
    set_in(32'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_cnt = 0;

    // Load-use table: each candidate followed by the bubble that clears the lw
    for (int i = 0; i < 14; i++) begin
      set_in(lu[i].fd, lw3, lu[i].ctl, 1'b0);
      cyc(lu[i].hit ? Q_LU : Q_NONE, 1'b0, 1'b0, 32'd0);
      set_in(lu[i].fd, 32'd0, 32'd0, 1'b0);
      cyc(Q_NONE, 1'b0, 1'b0, 32'd0);
    end

    // Redirect beats a simultaneous load-use, and flushes on its own
    set_in(lu[0].fd, lw3, lu[0].ctl, 1'b1);
    cyc(Q_FLUSH, 1'b0, 1'b0, 32'd0);
    set_in(32'd0, 32'd0, 32'd0, 1'b1);
    cyc(Q_FLUSH, 1'b0, 1'b0, 32'd0);
    set_in(32'd0, 32'd0, 32'd0, 1'b0);
    cyc(Q_NONE, 1'b0, 1'b0, 32'd0);

    // mul with result after 32 BUSY cycles; a load-use pattern is overridden meanwhile
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    exp_cnt = 0;
    set_in(lu[0].fd, mul_i, 32'd0, 1'b0);
    cyc(Q_MULT, 1'b0, 1'b0, 32'd0);
    set_in(lu[0].fd, mul_i, lu[0].ctl, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      hz.multdiv_ready  = (i == 32);
      hz.multdiv_result = (i == 32) ? 32'h0000_00C8 : 32'h0000_1234;
      cyc(Q_BUSY, 1'b0, 1'b0, 32'd0);
    end
    hz.multdiv_ready = 1'b0; hz.multdiv_result = 32'h5555_5555;
    cyc(Q_DONE, 1'b1, 1'b0, 32'h0000_00C8);
    set_in(32'd0, 32'd0, 32'd0, 1'b0);
    cyc(Q_NONE, 1'b1, 1'b0, 32'h0000_00C8);

    // div that never gets ready: forced completion after 40 BUSY cycles
    hz.multdiv_result = 32'hDEAD_BEEF;
    set_in(32'd0, div_i, 32'd0, 1'b0);
    cyc(Q_DIV, 1'b1, 1'b0, 32'h0000_00C8);
    for (int i = 1; i <= 40; i++) cyc(Q_BUSY, 1'b0, 1'b0, 32'd0);
    cyc(Q_DONE, 1'b1, 1'b1, 32'd0);

    // Back-to-back mul detected in the IDLE cycle right after DONE, exception on ready
    set_in(32'd0, mul_i, 32'd0, 1'b0);
    cyc(Q_MULT, 1'b1, 1'b1, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      hz.multdiv_ready = (i == 3); hz.multdiv_exception = (i == 3);
      hz.multdiv_result = 32'h0000_ABCD;
      cyc(Q_BUSY, 1'b0, 1'b0, 32'd0);
    end
    hz.multdiv_ready = 1'b0; hz.multdiv_exception = 1'b0;
    cyc(Q_DONE, 1'b1, 1'b1, 32'h0000_ABCD);
    set_in(32'd0, 32'd0, 32'd0, 1'b0);
    cyc(Q_NONE, 1'b1, 1'b1, 32'h0000_ABCD);

    // Asynchronous reset mid-BUSY, then a stale ready must be ignored
    set_in(32'd0, mul_i, 32'd0, 1'b0);
    cyc(Q_MULT, 1'b0, 1'b0, 32'd0);
    repeat (5) cyc(Q_BUSY, 1'b0, 1'b0, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    set_in(32'd0, 32'd0, 32'd0, 1'b0);
    hz.multdiv_ready = 1'b1; hz.multdiv_result = 32'h0000_0077;
    exp_cnt = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) cyc(Q_NONE, 1'b1, 1'b0, 32'd0);
    hz.multdiv_ready = 1'b0;

    @(posedge clock);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller sitting alongside the D/X latch, directly upstream of the bypass unit.
- Decides when the F/D and D/X latches hold, flush or take a bubble, so that the X-stage bypass selectors only ever see hazards they can resolve.
- Handles three cases: load-use stalls, taken-branch/jump flushes, and sequencing of the multi-cycle multdiv unit (start pulse, wait, result capture, timeout).
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MD_TIMEOUT, 40: max BUSY cycles waiting for multdiv_ready before forced completion.
- CNT_W, 32: width of stall_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IR_FD  in  32  instruction in F/D latch.
- IR_DX  in  32  instruction in D/X latch.
- ctrl_dx  in  32  D/X control word: [31:27] dest reg, [15] RWE, [13] mem_to_reg, [7] jr.
- branch_taken  in  1  branch/jump redirect resolved in X this cycle.
- multdiv_ready  in  1  multdiv result valid.
- multdiv_exception  in  1  multdiv exception, sampled with ready.
- multdiv_result  in  32  multdiv result.
- stall_pc  out  1  hold PC.
- stall_fd  out  1  hold F/D latch.
- stall_dx  out  1  hold D/X latch.
- flush_fd  out  1  load nop into F/D.
- nop_dx  out  1  load nop into D/X (bubble).
- nop_xm  out  1  load nop into X/M.
- ctrl_MULT  out  1  one-cycle multiply start.
- ctrl_DIV  out  1  one-cycle divide start.
- md_result  out  32  registered multdiv result.
- md_valid  out  1  md_result to be captured by X/M this cycle.
- md_exception  out  1  registered exception for the completing op (ready-exception or timeout).
- stall_count  out  CNT_W  saturating count of cycles with stall_pc=1.

Behaviour:
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2]. R-type opcode 00000. mul = R-type with aluop 00110; div = R-type with aluop 00111.
- Reset (async, reset_n=0): state IDLE, counters 0, md_result 0, md_valid 0, md_exception 0, stall_count 0. All combinational outputs evaluate to 0 while in reset.
- Load-use condition:
  - Requires ctrl_dx[13]=1, ctrl_dx[15]=1 and ctrl_dx[31:27]≠0.
  - Also requires ctrl_dx[31:27] to match a source register of IR_FD:
    - R-type: rs or rt.
    - addi, lw: rs.
    - sw: rs only. The data register is covered by memory-data bypass.
    - bne, blt: rd or rs.
    - jr: rd.
  - Action: stall_pc=stall_fd=1 and nop_dx=1 for exactly one cycle. No repeat, because the bubble clears the DX lw.
- Flush: branch_taken=1 gives flush_fd=1 and nop_dx=1, with stall_pc=stall_fd=0. Flush has priority over a simultaneous load-use stall, and the stall is suppressed.
- Multdiv FSM. States: IDLE, BUSY, DONE.
  - IDLE: if IR_DX is mul/div, pulse ctrl_MULT or ctrl_DIV for this cycle only, clear cycle counter, go BUSY. Assert stall_pc, stall_fd, stall_dx, nop_xm in this cycle.
  - BUSY: stall_pc, stall_fd, stall_dx, nop_xm held 1; counter increments.
    - If multdiv_ready: latch multdiv_result into md_result and multdiv_exception into md_exception, go DONE.
    - Else if counter reaches MD_TIMEOUT-1: md_result←0, md_exception←1, go DONE.
  - DONE: stalls deasserted, md_valid=1 for exactly one cycle, D/X advances this edge, go IDLE.
- Back-to-back mul/div: the new instruction in D/X is detected in the following IDLE cycle. Minimum spacing between start pulses is 3 cycles plus multdiv latency.
- Load-use while the multdiv FSM is not IDLE: the multdiv stall dominates. The load-use check is re-evaluated once the FSM returns to IDLE.
- stall_count increments each cycle stall_pc=1 and saturates at all-ones.
- reset_n asserted mid-BUSY: immediate return to IDLE with no start pulse. A stale multdiv_ready afterwards is ignored in IDLE.

Test Plan:
- Load-use: IR_DX = lw $3, IR_FD = add $4,$3,$5 → one cycle of stall_pc=stall_fd=nop_dx=1, then 0; stall_count=1.
- $r0 / sw-data exemption: lw $0 with add using $0 → no stall. lw $3 followed by sw $3,0($6) → no stall. sw $5,0($3) after lw $3 → stall.
- Flush priority: branch_taken=1 together with a load-use condition → flush_fd=nop_dx=1, stall_pc=0.
- mul completes: ctrl_MULT pulses 1 cycle; multdiv_ready after 32 cycles with result 0x0000_00C8 → md_valid=1 for 1 cycle, md_result=0xC8, stall_count=33.
- Timeout: MD_TIMEOUT=40, div with multdiv_ready never asserted → DONE after 40 BUSY cycles, md_exception=1, md_result=0.
- Async reset mid-BUSY: drop reset_n asynchronously → all outputs 0 immediately. Later multdiv_ready=1 causes no md_valid.
